// File: rtl/pc_pkg.sv
// Shared types and default vectors for the fetch-stage program counter.
package pc_pkg;

    // Redirect class held by the pending buffer. A higher value means a
    // higher-priority source.
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        JUMP   = 2'd1,
        BRANCH = 2'd2
    } redirect_class_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

endpackage

// File: rtl/pc_unit_if.sv
// Request/result bundle between the pipeline control logic and the PC unit.
interface pc_unit_if #(
    parameter int WIDTH = 32
);
    logic             Stall;
    logic             Jump;
    logic [WIDTH-1:0] JumpTarget;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchTarget;
    logic             Exception;
    logic [WIDTH-1:0] ExcPC;
    logic [WIDTH-1:0] PCResult;
    logic [WIDTH-1:0] PCPlusInc;
    logic             Flush;
    logic             RedirectPending;
    logic [WIDTH-1:0] EPC;

    // Pipeline control side: issues requests, observes the PC.
    modport master (
        output Stall, Jump, JumpTarget, BranchTaken, BranchTarget, Exception, ExcPC,
        input  PCResult, PCPlusInc, Flush, RedirectPending, EPC
    );

    // PC unit side.
    modport slave (
        input  Stall, Jump, JumpTarget, BranchTaken, BranchTarget, Exception, ExcPC,
        output PCResult, PCPlusInc, Flush, RedirectPending, EPC
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// One-entry pending-redirect register. While the pipe is stalled it keeps
// the highest-class redirect seen; an equal or higher class replaces the
// stored entry, a lower class is dropped.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clear,
    input  logic             capture,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_target,
    output logic             valid,
    output logic [WIDTH-1:0] target
);

    redirect_class_t  class_reg;
    logic [WIDTH-1:0] target_reg;
    redirect_class_t  req_class;
    logic [WIDTH-1:0] req_target;

    // Classify the incoming request; branch beats jump when both are present.
    always_comb begin
        req_class  = NONE;
        req_target = jump_target;
        if (branch) begin
            req_class  = BRANCH;
            req_target = branch_target;
        end else if (jump) begin
            req_class  = JUMP;
        end
    end

    // Entry register: clear dominates capture; replace only on equal/higher class.
    always_ff @(posedge clk) begin
        if (srst) begin
            class_reg  <= NONE;
            target_reg <= '0;
        end else if (clear) begin
            class_reg  <= NONE;
        end else if (capture && (req_class != NONE) && (req_class >= class_reg)) begin
            class_reg  <= req_class;
            target_reg <= req_target;
        end
    end

    assign valid  = (class_reg != NONE);
    assign target = target_reg;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, stall hold, prioritised
// redirects (exception > stall > branch > jump > pending > increment),
// exception PC capture and a one-cycle IF/ID flush pulse.
module pc_unit
    import pc_pkg::*;
#(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter logic [31:0]        EXC_VECTOR   = EXC_VECTOR_DEF,
    parameter int                 INC          = 4
) (
    input  logic      Clk,
    input  logic      Reset,
    pc_unit_if.slave  bus
);

    // Clears the sub-INC offset bits so every target is instruction aligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(INC - 1);
    localparam logic [WIDTH-1:0] EXC_TARGET = WIDTH'(EXC_VECTOR) & ALIGN_MASK;
    localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

    logic [WIDTH-1:0] pc_reg,  pc_next;
    logic [WIDTH-1:0] epc_reg, epc_next;
    logic             flush_reg, flush_next;
    logic [WIDTH-1:0] jump_target_aligned;
    logic [WIDTH-1:0] branch_target_aligned;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_target;
    logic             pend_clear;

    assign jump_target_aligned   = bus.JumpTarget   & ALIGN_MASK;
    assign branch_target_aligned = bus.BranchTarget & ALIGN_MASK;

    // Any unstalled edge either applies or supersedes the pending entry, and
    // an exception always discards it.
    assign pend_clear = bus.Exception | ~bus.Stall;

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .clk           (Clk),
        .srst          (Reset),
        .clear         (pend_clear),
        .capture       (bus.Stall),
        .jump          (bus.Jump),
        .jump_target   (jump_target_aligned),
        .branch        (bus.BranchTaken),
        .branch_target (branch_target_aligned),
        .valid         (pend_valid),
        .target        (pend_target)
    );

    // Priority mux selecting the next PC, EPC and flush.
    always_comb begin
        pc_next    = pc_reg + INC_W;
        epc_next   = epc_reg;
        flush_next = 1'b0;
        if (bus.Exception) begin
            pc_next    = EXC_TARGET;
            epc_next   = bus.ExcPC;
            flush_next = 1'b1;
        end else if (bus.Stall) begin
            pc_next    = pc_reg;
        end else if (bus.BranchTaken) begin
            pc_next    = branch_target_aligned;
            flush_next = 1'b1;
        end else if (bus.Jump) begin
            pc_next    = jump_target_aligned;
            flush_next = 1'b1;
        end else if (pend_valid) begin
            pc_next    = pend_target;
            flush_next = 1'b1;
        end
    end

    // PC, EPC and flush registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg    <= RESET_VECTOR;
            epc_reg   <= '0;
            flush_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            epc_reg   <= epc_next;
            flush_reg <= flush_next;
        end
    end

    assign bus.PCResult        = pc_reg;
    assign bus.PCPlusInc       = pc_reg + INC_W;
    assign bus.Flush           = flush_reg;
    assign bus.RedirectPending = pend_valid;
    assign bus.EPC             = epc_reg;

endmodule
